// File: rtl/sc01_pkg.sv
// Shared definitions for the SC-01 command path: field widths, the STOP code,
// FSM state encoding and default timing constants.
package sc01_pkg;

    localparam int PH_W    = 6;
    localparam int PITCH_W = 2;
    localparam int CMD_W   = PH_W + PITCH_W;

    localparam logic [PH_W-1:0] PH_STOP = 6'd63;

    localparam int DEF_DEPTH        = 8;
    localparam int DEF_SETUP_CYC    = 2;
    localparam int DEF_STROBE_CYC   = 2;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } sc01_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int bits_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sc01_cmd_fifo.sv
// Synchronous command FIFO with registered status and a registered head read:
// rd_data updates only on a pop and holds its value otherwise.
module sc01_cmd_fifo
    import sc01_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = CMD_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic             full_reg;
    logic             empty_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push;
    logic             do_pop;

    // Status is judged on the registered flags, so a write while full is
    // dropped even when a pop happens in the same cycle.
    assign do_push = push && !full_reg && !flush;
    assign do_pop  = pop && !empty_reg && !flush;

    always_comb begin
        level_next = level_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            rd_data_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            level_reg <= level_next;
            full_reg  <= (level_next == (AW+1)'(DEPTH));
            empty_reg <= (level_next == '0);
        end
    end

    assign rd_data = rd_data_reg;
    assign level   = level_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/sc01_phoneme_queue.sv
// Buffers CPU phoneme writes and hands them to the SC-01 one at a time:
// setup, latch strobe, then wait for AR (or a timeout) before the next one.
module sc01_phoneme_queue
    import sc01_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int STROBE_CYC   = DEF_STROBE_CYC,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [CMD_W-1:0]        wr_data,
    input  logic                    flush,
    input  logic                    ar,
    output logic [PH_W-1:0]         ph_code,
    output logic [PITCH_W-1:0]      pitch,
    output logic                    latch,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CNT_MAX = ((SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC) - 1;
    localparam int CNT_W   = bits_for(CNT_MAX);
    localparam int TO_W    = bits_for(BUSY_TIMEOUT);

    sc01_state_e      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic [TO_W-1:0]  to_inc;
    logic             ar_seen_reg;
    logic             latch_reg;
    logic             busy_reg;
    logic             overflow_reg;
    logic             wr_pend_reg;
    logic [CMD_W-1:0] wr_data_reg;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             timed_out;
    logic [CMD_W-1:0] head_data;

    // CPU writes are captured first and pushed one edge later; flush discards
    // both the captured write and any write arriving with it.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_pend_reg <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            wr_pend_reg <= wr_en;
            if (wr_en) begin
                wr_data_reg <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            overflow_reg <= 1'b0;
        end else if (wr_pend_reg && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty && !flush;

    sc01_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_pend_reg),
        .push_data (wr_data_reg),
        .pop       (fifo_pop),
        .flush     (flush),
        .rd_data   (head_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign to_inc    = (to_cnt_reg == TO_W'(BUSY_TIMEOUT)) ? to_cnt_reg : to_cnt_reg + 1'b1;
    // Timeout only applies when AR never went low, i.e. the code was ignored.
    assign timed_out = (to_inc == TO_W'(BUSY_TIMEOUT)) && !ar_seen_reg && ar;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            to_cnt_reg  <= '0;
            ar_seen_reg <= 1'b0;
            latch_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            busy_reg <= (state_reg != ST_IDLE) || !fifo_empty || wr_pend_reg;
            unique case (state_reg)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cnt_reg   <= CNT_W'(SETUP_CYC - 1);
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == '0) begin
                        cnt_reg     <= CNT_W'(STROBE_CYC - 1);
                        to_cnt_reg  <= '0;
                        ar_seen_reg <= 1'b0;
                        latch_reg   <= 1'b1;
                        state_reg   <= ST_STROBE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (flush) begin
                        latch_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_inc;
                        if (!ar) begin
                            ar_seen_reg <= 1'b1;
                        end
                        if (cnt_reg == '0) begin
                            latch_reg <= 1'b0;
                            state_reg <= ST_WAIT;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    to_cnt_reg <= to_inc;
                    if (!ar) begin
                        ar_seen_reg <= 1'b1;
                    end
                    if ((ar_seen_reg && ar) || timed_out) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ph_code  = head_data[PH_W-1:0];
    assign pitch    = head_data[CMD_W-1:PH_W];
    assign latch    = latch_reg;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_sc01_phoneme_queue.sv
// Directed and randomized checks of the phoneme queue against an expected-phoneme
// queue and strobe timing derived from the setup/strobe/AR rules.
module tb_sc01_phoneme_queue;
    import sc01_pkg::*;

    localparam int DEPTH        = 8;
    localparam int SETUP_CYC    = 2;
    localparam int STROBE_CYC   = 2;
    localparam int BUSY_TIMEOUT = 16;
    localparam int AR_LOW_CYC   = 50;
    localparam int AR_NORMAL    = 0;
    localparam int AR_HOLD      = 1;
    localparam int AR_NEVER     = 2;
    // Strobe start relative to the write edge, and between consecutive strobes.
    localparam int FIRST_LAT    = 2 + SETUP_CYC;
    localparam int AR_SPACING   = 1 + AR_LOW_CYC + 1 + 1 + SETUP_CYC;
    localparam int TO_SPACING   = BUSY_TIMEOUT + 1 + SETUP_CYC;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ar;
    logic [5:0] ph_code;
    logic [1:0] pitch;
    logic       latch;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;

    sc01_phoneme_queue #(
        .DEPTH        (DEPTH),
        .SETUP_CYC    (SETUP_CYC),
        .STROBE_CYC   (STROBE_CYC),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .ar       (ar),
        .ph_code  (ph_code),
        .pitch    (pitch),
        .latch    (latch),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy)
    );

    typedef struct {
        int         start;
        int         len;
        logic [5:0] code;
        logic [1:0] pitch;
        bit         stable;
    } strobe_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         ar_mode = AR_NORMAL;
    strobe_t    strobes[$];
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Speech-block model: AR drops one cycle after latch rises and stays low
    // AR_LOW_CYC cycles (or forever / never, depending on ar_mode).
    initial begin
        int  ar_low_cnt;
        bit  ar_arm;
        bit  lat_prev;
        ar = 1'b1;
        ar_low_cnt = 0;
        ar_arm = 0;
        lat_prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ar_arm) begin
                ar = 1'b0;
                ar_low_cnt = AR_LOW_CYC;
                ar_arm = 0;
            end else if (ar_low_cnt > 0) begin
                ar_low_cnt--;
                if (ar_low_cnt == 0 && ar_mode != AR_HOLD) ar = 1'b1;
            end else if (ar_mode != AR_HOLD) begin
                ar = 1'b1;
            end
            if (latch && !lat_prev && ar_mode != AR_NEVER) ar_arm = 1;
            lat_prev = latch;
        end
    end

    // Strobe monitor: records start edge, length and the code held during latch.
    initial begin
        strobe_t cur;
        bit      in_strobe;
        in_strobe = 0;
        cur = '{start: 0, len: 0, code: '0, pitch: '0, stable: 1'b1};
        forever begin
            @(negedge clk);
            if (latch === 1'b1) begin
                if (!in_strobe) begin
                    in_strobe = 1;
                    cur.start = cyc;
                    cur.len = 0;
                    cur.code = ph_code;
                    cur.pitch = pitch;
                    cur.stable = 1'b1;
                end
                cur.len++;
                if (ph_code !== cur.code || pitch !== cur.pitch) cur.stable = 1'b0;
            end else if (in_strobe) begin
                in_strobe = 0;
                strobes.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk("idle_within_budget", busy, 0);
    endtask

    task automatic check_strobes(input int first_start, input int spacing);
        int         prev_start;
        logic [7:0] e;
        strobe_t    s;
        chk("strobe_count", strobes.size(), exp_q.size());
        prev_start = -1;
        while (exp_q.size() > 0 && strobes.size() > 0) begin
            e = exp_q.pop_front();
            s = strobes.pop_front();
            chk("strobe_code", s.code, e[5:0]);
            chk("strobe_pitch", s.pitch, e[7:6]);
            chk("strobe_len", s.len, STROBE_CYC);
            chk("strobe_stable", s.stable, 1);
            if (prev_start < 0) begin
                if (first_start >= 0) chk("strobe_start", s.start, first_start);
            end else if (spacing > 0) begin
                chk("strobe_spacing", s.start - prev_start, spacing);
            end
            prev_start = s.start;
        end
        exp_q.delete();
        strobes.delete();
    endtask

    initial begin
        int         n0;
        int         k;
        logic [7:0] d;
        logic [7:0] w[$];

        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        flush = 1'b0;
        repeat (3) tick();
        chk("rst_ph_code", ph_code, 0);
        chk("rst_pitch", pitch, 0);
        chk("rst_latch", latch, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // Single phoneme 0x15 with exact edge timing.
        write_byte(8'h15);
        n0 = cyc;
        exp_q.push_back(8'h15);
        tick();
        chk("t1_empty_n1", empty, 0);
        chk("t1_busy_n1", busy, 1);
        tick();
        chk("t1_ph_code_n2", ph_code, 8'h15);
        chk("t1_pitch_n2", pitch, 0);
        chk("t1_latch_n2", latch, 0);
        chk("t1_level_n2", level, 0);
        tick_to(n0 + FIRST_LAT - 1);
        chk("t1_latch_pre", latch, 0);
        tick();
        chk("t1_latch_rise", latch, 1);
        tick();
        chk("t1_latch_hold", latch, 1);
        tick();
        chk("t1_latch_fall", latch, 0);
        tick_to(n0 + FIRST_LAT + AR_LOW_CYC + 2);
        chk("t1_busy_last", busy, 1);
        tick();
        chk("t1_busy_low", busy, 0);
        chk("t1_ph_code_hold", ph_code, 8'h15);
        check_strobes(n0 + FIRST_LAT, 0);

        // Directed burst including STOP, then randomized bursts.
        d = {2'b00, PH_STOP};
        w = '{8'h01, 8'h42, d};
        foreach (w[i]) begin
            write_byte(w[i]);
            if (i == 0) n0 = cyc;
            exp_q.push_back(w[i]);
        end
        wait_idle(400);
        check_strobes(n0 + FIRST_LAT, AR_SPACING);

        for (int b = 0; b < 3; b++) begin
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                d = 8'($urandom_range(0, 255));
                write_byte(d);
                if (i == 0) n0 = cyc;
                exp_q.push_back(d);
            end
            wait_idle(k * 60 + 100);
            check_strobes(n0 + FIRST_LAT, AR_SPACING);
        end

        // Speech block ignores the codes: WAIT leaves on the timeout.
        ar_mode = AR_NEVER;
        tick();
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(0, 255));
            write_byte(d);
            if (i == 0) n0 = cyc;
            exp_q.push_back(d);
        end
        tick_to(n0 + 6);
        chk("t4_level_wait", level, 1);
        chk("t4_busy_wait", busy, 1);
        tick_to(n0 + FIRST_LAT + TO_SPACING - SETUP_CYC);
        chk("t4_level_second", level, 0);
        chk("t4_busy_second", busy, 1);
        tick_to(n0 + FIRST_LAT + 2 * TO_SPACING - SETUP_CYC - 1);
        chk("t4_busy_last", busy, 1);
        tick();
        chk("t4_busy_low", busy, 0);
        check_strobes(n0 + FIRST_LAT, TO_SPACING);
        ar_mode = AR_NORMAL;
        tick();

        // Overflow: AR held low keeps the first phoneme playing.
        ar_mode = AR_HOLD;
        tick();
        w.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom_range(0, 255));
            write_byte(d);
            if (i == 0) n0 = cyc;
            w.push_back(d);
        end
        tick();
        tick();
        chk("t3_level_full", level, DEPTH);
        chk("t3_full", full, 1);
        chk("t3_overflow_clear", overflow, 0);
        write_byte(8'($urandom_range(0, 255)));
        tick();
        chk("t3_overflow_set", overflow, 1);
        chk("t3_level_kept", level, DEPTH);
        exp_q.push_back(w.pop_front());
        check_strobes(n0 + FIRST_LAT, 0);
        ar_mode = AR_NORMAL;
        foreach (w[i]) exp_q.push_back(w[i]);
        wait_idle(DEPTH * 60 + 200);
        check_strobes(-1, AR_SPACING);
        chk("t3_overflow_sticky", overflow, 1);

        // Flush during STROBE with three entries queued.
        w.delete();
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            write_byte(d);
            if (i == 0) n0 = cyc;
            w.push_back(d);
        end
        tick();
        chk("t5_latch_before", latch, 1);
        chk("t5_level_before", level, 3);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'($urandom_range(0, 255));
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("t5_latch_after", latch, 0);
        chk("t5_level_after", level, 0);
        chk("t5_empty_after", empty, 1);
        chk("t5_overflow_after", overflow, 0);
        tick();
        chk("t5_busy_idle", busy, 0);
        chk("t5_level_no_write", level, 0);
        repeat (80) tick();
        chk("t5_strobe_count", strobes.size(), 1);
        if (strobes.size() > 0) begin
            chk("t5_cut_len", strobes[0].len, 1);
            chk("t5_cut_code", strobes[0].code, w[0][5:0]);
        end
        strobes.delete();

        // Reset during WAIT with two entries queued.
        w.delete();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            write_byte(d);
            if (i == 0) n0 = cyc;
            w.push_back(d);
        end
        tick_to(n0 + 10);
        chk("t6_level_wait", level, 2);
        chk("t6_busy_wait", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_ph_code", ph_code, 0);
        chk("t6_pitch", pitch, 0);
        chk("t6_latch", latch, 0);
        chk("t6_level", level, 0);
        chk("t6_empty", empty, 1);
        chk("t6_full", full, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_busy", busy, 0);
        repeat (100) tick();
        chk("t6_busy_after", busy, 0);
        exp_q.push_back(w[0]);
        check_strobes(n0 + FIRST_LAT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
